exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 instr_valid  input  1  upstream has an instruction on instr.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 alu_src  output  1  operand-B select for the ALU operand mux: 1 = immediate, 0 = register rdb.
REQ-008 alu_op  output  4  ALU operation code.
REQ-009 mem_req  output  1  data-memory request, held until accepted.
REQ-010 mem_we  output  1  store qualifier, valid with mem_req.
REQ-011 mem_ready  input  1  memory accepts or completes the request.
REQ-012 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 pc_we  output  1  PC advance, one-cycle pulse per retired instruction.
REQ-014 illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 A transfer SHALL occur on a rising edge where instr_valid=1 and instr_ready=1; instr SHALL be captured into an internal register (ir).
REQ-017 instr_ready SHALL be 1 only in IDLE with reset=1; instr SHALL be ignored at all other times.
REQ-018 The FSM SHALL have states IDLE, DECODE, EXEC, MEM, WB; all outputs SHALL be Moore functions of the state and ir.
REQ-019 IDLE -> DECODE SHALL occur on a transfer; otherwise the FSM SHALL stay in IDLE.
REQ-020 In DECODE, ir[6:0] SHALL be classified as follows: 0110011 = R; 0010011 = I; 0000011 = LOAD; 0100011 = STORE; 1100011 = BRANCH; any other value = illegal.
REQ-021 DECODE with an illegal opcode SHALL pulse illegal for that cycle and go to IDLE without pc_we.
REQ-022 DECODE with a legal opcode SHALL go to EXEC.
REQ-023 alu_src SHALL be 1 in EXEC for I, LOAD and STORE, and 0 for R and BRANCH; outside EXEC it SHALL hold its EXEC value and SHALL be 0 after reset.
REQ-024 alu_op SHALL be decoded per class:
  - R: {ir[30], ir[14:12]}.
  - I: {ir[30] when ir[14:12]=101, else 0; ir[14:12]}.
  - LOAD/STORE: 0000 (add).
  - BRANCH: 1000 (sub).
  - Reset value: 0000.
REQ-025 EXEC SHALL last exactly one cycle and then:
  - R or I -> WB.
  - LOAD or STORE -> MEM.
  - BRANCH -> IDLE, with pc_we=1 during EXEC.
REQ-026 In MEM, mem_req SHALL be 1, with mem_we=1 for STORE and 0 for LOAD, and SHALL stay asserted until the cycle in which mem_ready=1.
REQ-027 MEM exit SHALL occur in the cycle where mem_ready=1:
  - LOAD -> WB.
  - STORE -> IDLE, with pc_we=1 in that cycle.
REQ-028 mem_ready SHALL be ignored outside MEM.
REQ-029 WB SHALL last one cycle, pulse pc_we, pulse rf_we unless ir[11:7]=0 (x0), and then go to IDLE.
REQ-030 Latency from transfer edge to next instr_ready=1 SHALL be:
  - R/I: 4 cycles.
  - BRANCH: 3 cycles.
  - LOAD: 5 + W cycles, where W is the number of mem_ready=0 cycles.
  - STORE: 4 + W cycles.
  - Illegal: 2 cycles.
REQ-031 pc_we, rf_we and illegal SHALL be mutually exclusive with one another except pc_we with rf_we in WB, and each SHALL be high for at most one cycle per instruction.

Reset
REQ-032 While reset=0, the state SHALL be IDLE, ir SHALL be 0, and all outputs SHALL be 0, including instr_ready.
REQ-033 Reset asserted mid-instruction, including in MEM with mem_req=1, SHALL abandon the instruction with no further pc_we/rf_we, and SHALL drop mem_req asynchronously.
REQ-034 After reset deassertion, instr_ready SHALL be 1 in the first cycle, and a transfer SHALL be possible on the first rising edge.

Structure
REQ-035 A shared package exec_seq_pkg SHALL hold:
  - opcode constants;
  - the state encoding (3-bit enum);
  - the instruction-class enum;
  - the ALU_ADD=0000 and ALU_SUB=1000 constants.
REQ-036 Opcode classification and alu_op generation SHALL live in one combinational sub-module, exec_decode; the FSM and ir SHALL live in exec_sequencer.

Verification
REQ-037 Reset behaviour: hold reset=0 for 3 cycles, then release -> all outputs 0 during reset, and instr_ready=1 in the first cycle after release.
REQ-038 R-type add: instr=0x002081B3 (add x3,x1,x2) -> expected response:
  - EXEC with alu_src=0, alu_op=0000;
  - WB with rf_we=1 and pc_we=1;
  - instr_ready=1 again 4 cycles after the transfer.
REQ-039 Load with wait states: instr=0x0040A183 (lw x3,4(x1)), with mem_ready=0 for 2 MEM cycles -> expected response:
  - alu_src=1, alu_op=0000;
  - mem_req=1, mem_we=0 held for 3 cycles;
  - then WB with rf_we=1.
REQ-040 Store with immediate acceptance: instr=0x0030A223 (sw x3,4(x1)), mem_ready=1 -> expected response: mem_we=1 for 1 cycle with pc_we=1 in the same cycle, and rf_we never asserted.
REQ-041 Corner cases:
  - instr=0x0000007F -> illegal pulse in DECODE, no pc_we, instr_ready=1 two cycles after the transfer.
  - addi x0,x0,1 (0x00100013) -> rf_we stays 0 and pc_we=1.
REQ-042 Reset mid-access: assert reset=0 in MEM with mem_req=1 -> mem_req=0 immediately, and no pc_we/rf_we after release.

Source files
------------

// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_seq_pkg
//  Description : Shared opcode constants, FSM state encoding, instruction
//                class enum and ALU constants for the execution sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package exec_seq_pkg;

    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5
    } instr_class_t;

    // Map a 7-bit major opcode onto the supported instruction classes.
    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            c_OPC_R:      cls = CLS_R;
            c_OPC_I:      cls = CLS_I;
            c_OPC_LOAD:   cls = CLS_LOAD;
            c_OPC_STORE:  cls = CLS_STORE;
            c_OPC_BRANCH: cls = CLS_BRANCH;
            default:      cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_decode.sv
`default_nettype none
// ============================================================================
//  Module      : exec_decode
//  Description : Combinational opcode classification and ALU control decode.
//  Revision    : 1.0  initial release
// ============================================================================
module exec_decode
    import exec_seq_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic         i_bit30,
    output instr_class_t o_class,
    output logic         o_alu_src,
    output logic [3:0]   o_alu_op
);

    assign o_class = classify(i_opcode);

    // Operand-B select and ALU opcode per class; only shifts-right use bit 30 for I-type.
    always_comb begin
        o_alu_src = 1'b0;
        o_alu_op  = c_ALU_ADD;
        case (o_class)
            CLS_R: begin
                o_alu_op = {i_bit30, i_funct3};
            end
            CLS_I: begin
                o_alu_src = 1'b1;
                o_alu_op  = {(i_funct3 == 3'b101) & i_bit30, i_funct3};
            end
            CLS_LOAD, CLS_STORE: begin
                o_alu_src = 1'b1;
            end
            CLS_BRANCH: begin
                o_alu_op = c_ALU_SUB;
            end
            default: begin
                o_alu_src = 1'b0;
                o_alu_op  = c_ALU_ADD;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sequencer
//  Description : Multi-cycle RV32I control sequencer (IDLE/DECODE/EXEC/MEM/WB)
//                driving ALU, data-memory, register-file and PC controls.
//  Revision    : 1.0  initial release
// ============================================================================
module exec_sequencer
    import exec_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        rf_we,
    output logic        pc_we,
    output logic        illegal,
    output logic        busy
);

    seq_state_t   r_state;
    seq_state_t   w_next_state;
    logic [31:0]  r_ir;
    logic         r_alu_src;
    logic [3:0]   r_alu_op;
    instr_class_t w_class;
    logic         w_dec_alu_src;
    logic [3:0]   w_dec_alu_op;
    logic         w_transfer;
    logic         w_unused_ir;

    // Ready is gated by reset so it reads 0 while reset is held low.
    assign instr_ready = reset & (r_state == ST_IDLE);
    assign w_transfer  = instr_valid & instr_ready;
    assign alu_src     = r_alu_src;
    assign alu_op      = r_alu_op;
    // Immediate and upper funct7 bits are not needed for sequencing.
    assign w_unused_ir = ^{r_ir[31], r_ir[29:15]};

    exec_decode u_decode (
        .i_opcode  (r_ir[6:0]),
        .i_funct3  (r_ir[14:12]),
        .i_bit30   (r_ir[30]),
        .o_class   (w_class),
        .o_alu_src (w_dec_alu_src),
        .o_alu_op  (w_dec_alu_op)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction register, loaded on every accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= 32'd0;
        end else if (w_transfer) begin
            r_ir <= instr;
        end
    end

    // ALU controls are latched on entry to EXEC and held until the next legal instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_src <= 1'b0;
            r_alu_op  <= c_ALU_ADD;
        end else if ((r_state == ST_DECODE) && (w_class != CLS_ILLEGAL)) begin
            r_alu_src <= w_dec_alu_src;
            r_alu_op  <= w_dec_alu_op;
        end
    end

    // Next-state logic and per-state control pulses.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        illegal      = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_transfer) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_class == CLS_ILLEGAL) begin
                    illegal      = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_class == CLS_BRANCH) begin
                    pc_we        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if ((w_class == CLS_LOAD) || (w_class == CLS_STORE)) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (w_class == CLS_STORE);
                if (mem_ready) begin
                    if (w_class == CLS_STORE) begin
                        pc_we        = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_we        = 1'b1;
                rf_we        = (r_ir[11:7] != 5'd0);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_sequencer
//  Description : Self-checking bench for exec_sequencer: directed cases plus
//                random instructions against a per-instruction outcome model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_ready = 1'b0;
    logic        instr_ready;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        rf_we;
    logic        pc_we;
    logic        illegal;
    logic        busy;

    int tests = 0;
    int fails = 0;

    exec_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .illegal     (illegal),
        .busy        (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Class codes used by the model: 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 branch.
    function automatic int cls_of(input logic [6:0] op);
        if (op == 7'h33) return 1;
        if (op == 7'h13) return 2;
        if (op == 7'h03) return 3;
        if (op == 7'h23) return 4;
        if (op == 7'h63) return 5;
        return 0;
    endfunction

    // Issue one instruction, feed mem_ready with `waits` stall cycles, and
    // compare the observed per-instruction totals with the expected outcome.
    task automatic run_instr(input logic [31:0] ins, input int waits, input string tag, input bit now);
        int          cls;
        int          exp_lat, exp_rf, exp_mreq, exp_mwe;
        logic        exp_src;
        logic [3:0]  exp_op;
        int          lat, n_pc, n_rf, n_ill, n_mreq, n_mwe, n_pcmwe, n_excl, memcnt;
        logic        src_seen;
        logic [3:0]  op_seen;
        logic [2:0]  f3;

        cls = cls_of(ins[6:0]);
        f3  = ins[14:12];
        case (cls)
            0:       exp_lat = 2;
            3:       exp_lat = 5 + waits;
            4:       exp_lat = 4 + waits;
            5:       exp_lat = 3;
            default: exp_lat = 4;
        endcase
        exp_rf   = ((cls >= 1) && (cls <= 3) && (ins[11:7] != 5'd0)) ? 1 : 0;
        exp_mreq = ((cls == 3) || (cls == 4)) ? waits + 1 : 0;
        exp_mwe  = (cls == 4) ? waits + 1 : 0;
        exp_src  = (cls == 2) || (cls == 3) || (cls == 4);
        case (cls)
            1:       exp_op = {ins[30], f3};
            2:       exp_op = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
            5:       exp_op = 4'd8;
            default: exp_op = 4'd0;
        endcase

        if (!now) @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        mem_ready   = 1'($urandom_range(0, 1));
        #1;
        check({tag, " ready_before"}, 32'(instr_ready), 32'd1);
        @(posedge clk);

        lat = 0; n_pc = 0; n_rf = 0; n_ill = 0; n_mreq = 0; n_mwe = 0;
        n_pcmwe = 0; n_excl = 0; memcnt = 0;
        src_seen = 1'b0; op_seen = 4'd0;
        for (int k = 1; (k <= 40) && (lat == 0); k++) begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (memcnt == waits);
                memcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (instr_ready) begin
                instr_valid = 1'b0;
                lat = k;
            end else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom;
            end
            #1;
            n_pc  += int'(pc_we);
            n_rf  += int'(rf_we);
            n_ill += int'(illegal);
            if (mem_req) n_mreq++;
            if (mem_we) n_mwe++;
            if (pc_we && mem_we) n_pcmwe++;
            if (illegal && (pc_we || rf_we)) n_excl++;
            if (rf_we && !pc_we) n_excl++;
            if (k == 2) begin
                src_seen = alu_src;
                op_seen  = alu_op;
            end
        end
        instr_valid = 1'b0;

        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " pc_we_count"}, 32'(n_pc), (cls == 0) ? 32'd0 : 32'd1);
        check({tag, " rf_we_count"}, 32'(n_rf), 32'(exp_rf));
        check({tag, " illegal_count"}, 32'(n_ill), (cls == 0) ? 32'd1 : 32'd0);
        check({tag, " mem_req_cycles"}, 32'(n_mreq), 32'(exp_mreq));
        check({tag, " mem_we_cycles"}, 32'(n_mwe), 32'(exp_mwe));
        check({tag, " pc_we_with_mem_we"}, 32'(n_pcmwe), (cls == 4) ? 32'd1 : 32'd0);
        check({tag, " exclusivity"}, 32'(n_excl), 32'd0);
        if (cls != 0) begin
            check({tag, " alu_src"}, 32'(src_seen), 32'(exp_src));
            check({tag, " alu_op"}, 32'(op_seen), 32'(exp_op));
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {instr_ready, alu_src, alu_op, mem_req, mem_we, rf_we, pc_we, illegal, busy, 2'b00};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [6:0]  op;
        int          cls;
        int          n_pc, n_rf;

        // Reset held low for three cycles with a pending request.
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("reset_outputs_zero", 32'(all_outs()), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        // First cycle after release: ready high and a transfer on the first edge.
        run_instr(32'h002081B3, 0, "add_x3_x1_x2", 1'b1);

        run_instr(32'h0040A183, 2, "lw_wait2", 1'b0);
        run_instr(32'h0030A223, 0, "sw_immediate", 1'b0);
        run_instr(32'h0000007F, 0, "illegal_7f", 1'b0);
        run_instr(32'h00100013, 0, "addi_x0", 1'b0);
        run_instr(32'h00208463, 0, "beq", 1'b0);
        run_instr(32'h4010D093, 0, "srai", 1'b0);
        run_instr(32'h40208033, 0, "sub_x0", 1'b0);
        run_instr(32'h0030A223, 3, "sw_wait3", 1'b0);

        // Reset asserted mid-cycle while a load is stalled in MEM.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'h0040A183;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int k = 0; (k < 10) && !mem_req; k++) @(negedge clk);
        check("midreset mem_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset mem_req_dropped", 32'(mem_req), 32'd0);
        check("midreset outputs_zero", 32'(all_outs()), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("midreset ready_after", 32'(instr_ready), 32'd1);
        n_pc = 0;
        n_rf = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_pc += int'(pc_we);
            n_rf += int'(rf_we);
        end
        check("midreset no_pc_we", 32'(n_pc), 32'd0);
        check("midreset no_rf_we", 32'(n_rf), 32'd0);
        check("midreset idle", 32'(busy), 32'd0);

        // Random instructions of every class with random stall counts.
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            cls = int'($urandom_range(0, 5));
            case (cls)
                1: ins[6:0] = 7'h33;
                2: ins[6:0] = 7'h13;
                3: ins[6:0] = 7'h03;
                4: ins[6:0] = 7'h23;
                5: ins[6:0] = 7'h63;
                default: begin
                    do begin
                        op = 7'($urandom);
                    end while (cls_of(op) != 0);
                    ins[6:0] = op;
                end
            endcase
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            run_instr(ins, int'($urandom_range(0, 3)), $sformatf("rand%0d_%08h", n, ins), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
